// File: rtl/tbs_pkg.sv
// tbs_pkg: shared state encoding and constant helpers for the TBS transmit scheduler (TBS_TX_PARITY_EN adds the parity state)
package tbs_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef TBS_TX_PARITY_EN
        S_PAR,
`endif
        S_STOP,
        S_GAP
    } state_t;

    function automatic int calc_bit_cyc(int clk_freq, int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int calc_pulse_cyc(int bit_cyc);
        return bit_cyc / 10;
    endfunction

    function automatic int clog2w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tbs_tx_sched_if.sv
// tbs_tx_sched_if: requester-side valid/ready byte handshake bundle for the TBS scheduler
interface tbs_tx_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/tbs_bit_timer.sv
// tbs_bit_timer: per-bit cycle counter with end-of-bit strobe and next-cycle low-pulse window
module tbs_bit_timer
    import tbs_pkg::*;
#(
    parameter int BIT_CYC   = 434,
    parameter int PULSE_CYC = 43
) (
    input  logic clk_50M,
    input  logic rst,
    input  logic restart,
    output logic bit_end,
    output logic pulse_win
);
    localparam int CW = clog2w(BIT_CYC);

    logic [CW-1:0] cyc_q, cyc_d;

    // pulse_win looks one cycle ahead so the line register can be loaded in time
    always_comb begin
        bit_end   = cyc_q == CW'(BIT_CYC - 1);
        cyc_d     = (restart || bit_end) ? '0 : cyc_q + 1'b1;
        pulse_win = cyc_d < CW'(PULSE_CYC);
    end

    // cycle counter register
    always_ff @(posedge clk_50M) cyc_q <= rst ? '0 : cyc_d;
endmodule

// File: rtl/tbs_tx_sched.sv
// tbs_tx_sched: round-robin arbiter and TBS pulse encoder for the shared serial line; TBS_TX_PARITY_EN adds an even-parity bit
module tbs_tx_sched
    import tbs_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int N_REQ     = 4,
    parameter int GAP_BITS  = 2
) (
    input  logic                       clk_50M,
    input  logic                       rst,
    tbs_tx_sched_if.slave              req,
    output logic                       TBS_out,
    output logic                       busy,
    output logic [clog2w(N_REQ)-1:0]   grant_id,
    output logic                       frame_done
);
    localparam int BIT_CYC   = calc_bit_cyc(CLK_FREQ, BAUD_RATE);
    localparam int PULSE_CYC = calc_pulse_cyc(BIT_CYC);
    localparam int GW        = clog2w(N_REQ);

    state_t        state_q, state_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [GW-1:0] ptr_q, ptr_d, grant_q, grant_d, win;
    logic          tbs_q, tbs_d, found, accept, bit_end, pulse_win, nxt_bit;
    int            idx;
`ifdef TBS_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    tbs_bit_timer #(.BIT_CYC(BIT_CYC), .PULSE_CYC(PULSE_CYC)) u_timer (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .restart   (accept),
        .bit_end   (bit_end),
        .pulse_win (pulse_win)
    );

    // pick the first pending requester at or after the round-robin pointer
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && req.req_valid[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
        accept = (state_q == S_IDLE) && found;
    end

    assign req.req_ready = accept ? N_REQ'(1) << win : '0;

    // frame sequencing; the line value is derived from the next state so TBS_out stays a flop
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        grant_d = grant_q;
        ptr_d   = accept ? ((int'(win) == N_REQ - 1) ? '0 : win + 1'b1) : ptr_q;
`ifdef TBS_TX_PARITY_EN
        par_d   = accept ? ^req.req_data[8*win +: 8] : par_q;
`endif
        unique case (state_q)
            S_IDLE:  if (accept) begin
                         state_d = S_START;
                         shreg_d = req.req_data[8*win +: 8];
                         grant_d = win;
                     end
            S_START: if (bit_end) begin
                         state_d = S_DATA;
                         bit_d   = '0;
                     end
            S_DATA:  if (bit_end) begin
                         shreg_d = shreg_q >> 1;
                         bit_d   = bit_q + 1'b1;
`ifdef TBS_TX_PARITY_EN
                         if (bit_q == 4'd7) state_d = S_PAR;
`else
                         if (bit_q == 4'd7) state_d = S_STOP;
`endif
                     end
`ifdef TBS_TX_PARITY_EN
            S_PAR:   if (bit_end) state_d = S_STOP;
`endif
            S_STOP:  if (bit_end) begin
                         state_d = (GAP_BITS == 0) ? S_IDLE : S_GAP;
                         bit_d   = '0;
                     end
            S_GAP:   if (bit_end) begin
                         bit_d = bit_q + 1'b1;
                         if (int'(bit_q) == GAP_BITS - 1) state_d = S_IDLE;
                     end
            default: state_d = S_IDLE;
        endcase
`ifdef TBS_TX_PARITY_EN
        nxt_bit = (state_d == S_START) ? 1'b0 :
                  (state_d == S_DATA)  ? shreg_d[0] :
                  (state_d == S_PAR)   ? par_q : 1'b1;
`else
        nxt_bit = (state_d == S_START) ? 1'b0 :
                  (state_d == S_DATA)  ? shreg_d[0] : 1'b1;
`endif
        tbs_d = nxt_bit | ~pulse_win;
    end

    // state registers; reset returns the line high and drops any partial byte
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            shreg_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            tbs_q   <= 1'b1;
`ifdef TBS_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            tbs_q   <= tbs_d;
`ifdef TBS_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign TBS_out    = tbs_q;
    assign busy       = state_q != S_IDLE;
    assign grant_id   = grant_q;
    assign frame_done = (state_q == S_STOP) && bit_end;
endmodule

// File: tb/tb_tbs_tx_sched.sv
// tb_tbs_tx_sched: randomized and directed checks of tbs_tx_sched against a frame-timing model with a loopback decoder
module tb_tbs_tx_sched;
    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 50_000;
    localparam int N        = 4;
    localparam int GAP      = 2;
    localparam int BIT      = 20;
    localparam int PULSE    = 2;
    localparam int SOFF     = 1;
`ifdef TBS_TX_PARITY_EN
    localparam int NSB      = 11;
    localparam int T1_LOWS  = 12;
    localparam int T1_DONE  = 220;
    localparam int SPACING  = 261;
`else
    localparam int NSB      = 10;
    localparam int T1_LOWS  = 10;
    localparam int T1_DONE  = 200;
    localparam int SPACING  = 241;
`endif
    localparam int FL = (NSB + GAP) * BIT;

    logic       clk_50M = 1'b0;
    logic       rst = 1'b1;
    logic       TBS_out, busy, frame_done;
    logic [1:0] grant_id;

    tbs_tx_sched_if #(.N_REQ(N)) rq();

    tbs_tx_sched #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .N_REQ(N), .GAP_BITS(GAP)) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .req        (rq),
        .TBS_out    (TBS_out),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 clk_50M = ~clk_50M;

    int         total = 0, bad = 0, cyc = 0;
    bit         chk_en = 0, rnd_mode = 0;
    logic [7:0] pend[N][$];
    bit         xfer[N];
    bit         m_act = 0, m_busy = 0;
    int         t0 = 0, m_ptr = 0, m_gid = 0;
    logic [7:0] m_byte = 8'h00;
    int         lg_id[$], lg_cyc[$];
    logic [7:0] dec_log[$];
    bit         d_on = 0;
    int         d_t = 0;
    logic [9:0] d_sh = '0;
    logic       prev_line = 1'b1;
    logic       ln[0:FL];
    int         me, mk, moff, wn;
    logic       et, ed;
    logic [N-1:0] er;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 50) $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic fbit(logic [7:0] b, int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef TBS_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk_50M) cyc <= cyc + 1;

    // reference model, per-cycle compare and loopback decoder
    always @(negedge clk_50M) begin
        if (chk_en) begin
            me     = cyc - t0;
            m_busy = m_act && me >= 1 && me <= FL;
            et = 1'b1;
            ed = 1'b0;
            if (m_busy) begin
                mk   = (me - 1) / BIT;
                moff = (me - 1) % BIT;
                et   = fbit(m_byte, mk) | (moff >= PULSE);
                ed   = me == NSB * BIT;
            end
            wn = -1;
            er = '0;
            if (!m_busy)
                for (int j = 0; j < N; j++)
                    if (wn < 0 && rq.req_valid[(m_ptr + j) % N]) wn = (m_ptr + j) % N;
            if (wn >= 0) er[wn] = 1'b1;
            chk("line", TBS_out, et);
            chk("busy", busy, m_busy);
            chk("grant_id", grant_id, m_gid);
            chk("frame_done", frame_done, ed);
            if (!rst) chk("req_ready", rq.req_ready, er);
            if (rst) d_on = 0;
            else if (d_on) begin
                moff = cyc - d_t;
                if (moff % BIT == SOFF) begin
                    d_sh[moff/BIT] = TBS_out;
                    if (moff / BIT == NSB - 2) begin
                        chk("rx_start", d_sh[0], 0);
                        chk("rx_byte", d_sh[8:1], m_byte);
`ifdef TBS_TX_PARITY_EN
                        chk("rx_parity", d_sh[9], ^d_sh[8:1]);
`endif
                        dec_log.push_back(d_sh[8:1]);
                        d_on = 0;
                    end
                end
            end else if (prev_line && !TBS_out) begin
                d_on = 1;
                d_t  = cyc;
            end
            prev_line = TBS_out;
            if (rst) begin
                m_act = 0; m_busy = 0; m_ptr = 0; m_gid = 0;
            end else if (wn >= 0) begin
                m_act  = 1;
                t0     = cyc;
                m_byte = rq.req_data[8*wn +: 8];
                m_gid  = wn;
                m_ptr  = (wn + 1) % N;
                xfer[wn] = 1;
                lg_id.push_back(wn);
                lg_cyc.push_back(cyc);
            end
        end
    end

    // requesters: present the head of each queue, drop it after a transfer
    initial forever begin
        @(posedge clk_50M);
        #1;
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) begin
                void'(pend[i].pop_front());
                xfer[i] = 0;
            end
            rq.req_valid[i] = pend[i].size() > 0 && (!rnd_mode || $urandom_range(3) != 0);
            rq.req_data[8*i +: 8] = rq.req_valid[i] ? pend[i][0] : 8'($urandom);
        end
    end

    function automatic bit idle_now();
        int s = 0;
        for (int i = 0; i < N; i++) s += pend[i].size() + int'(xfer[i]);
        return s == 0 && (!m_act || cyc - t0 > FL);
    endfunction

    task automatic wait_idle(input int lim);
        int w = 0;
        bit ok = 0;
        while (!ok && w < lim) begin
            @(posedge clk_50M);
            #2;
            w++;
            ok = idle_now();
        end
        chk("wait_idle", ok, 1);
    endtask

    task automatic wait_busy();
        int w = 0;
        do begin
            @(negedge clk_50M);
            w++;
        end while (!busy && w < 2000);
        chk("wait_busy", busy, 1);
    endtask

    task automatic capture(output int lows, output int done_at);
        lows = 0;
        done_at = -1;
        wait_busy();
        for (int e = 1; e <= FL; e++) begin
            ln[e] = TBS_out;
            if (!TBS_out) lows++;
            if (frame_done) done_at = e;
            if (e < FL) @(negedge clk_50M);
        end
    endtask

    task automatic do_reset();
        @(posedge clk_50M);
        #1 rst = 1;
        repeat (2) @(posedge clk_50M);
        #1 rst = 0;
    endtask

    initial begin
        int lows, dn, g0, n0;
        rq.req_valid = '0;
        rq.req_data  = '0;
        repeat (3) @(posedge clk_50M);
        #1 chk_en = 1;
        @(posedge clk_50M);
        #1 rst = 0;
        @(negedge clk_50M);
        chk("rst_line", TBS_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ready", rq.req_ready, 0);

        pend[0].push_back(8'h55);
        capture(lows, dn);
        chk("t1_lows", lows, T1_LOWS);
        chk("t1_done", dn, T1_DONE);
        chk("t1_start_low", ln[1], 0);
        chk("t1_start_rise", ln[3], 1);
        chk("t1_bit0", ln[21], 1);
        chk("t1_bit1", ln[41], 0);
        chk("t1_bit2", ln[61], 1);
        chk("t1_bit7", ln[161], 0);
        wait_idle(2000);

        n0 = dec_log.size();
        pend[1].push_back(8'hA3);
        pend[1].push_back(8'h00);
        pend[1].push_back(8'hFF);
        wait_idle(4000);
        chk("t2_count", dec_log.size(), n0 + 3);
        if (dec_log.size() >= n0 + 3) begin
            chk("t2_b0", dec_log[n0], 8'hA3);
            chk("t2_b1", dec_log[n0+1], 8'h00);
            chk("t2_b2", dec_log[n0+2], 8'hFF);
        end

        do_reset();
        g0 = lg_id.size();
        pend[0].push_back(8'h11);
        pend[1].push_back(8'h22);
        pend[2].push_back(8'h33);
        pend[3].push_back(8'h44);
        pend[0].push_back(8'h55);
        wait_idle(6000);
        chk("t3_count", lg_id.size(), g0 + 5);
        if (lg_id.size() >= g0 + 5) begin
            chk("t3_g0", lg_id[g0], 0);
            chk("t3_g1", lg_id[g0+1], 1);
            chk("t3_g2", lg_id[g0+2], 2);
            chk("t3_g3", lg_id[g0+3], 3);
            chk("t3_g4", lg_id[g0+4], 0);
            for (int i = 1; i < 5; i++) chk("t3_spacing", lg_cyc[g0+i] - lg_cyc[g0+i-1], SPACING);
        end

        do_reset();
        g0 = lg_id.size();
        pend[0].push_back(8'h5A);
        pend[0].push_back(8'hA5);
        pend[2].push_back(8'h66);
        wait_idle(4000);
        chk("t4_count", lg_id.size(), g0 + 3);
        if (lg_id.size() >= g0 + 3) begin
            chk("t4_g0", lg_id[g0], 0);
            chk("t4_g1", lg_id[g0+1], 2);
            chk("t4_g2", lg_id[g0+2], 0);
        end

        pend[1].push_back(8'hA3);
        wait_busy();
        n0 = dec_log.size();
        repeat (5 * BIT + 2) @(negedge clk_50M);
        @(posedge clk_50M);
        #1 rst = 1;
        @(posedge clk_50M);
        #1 rst = 0;
        @(negedge clk_50M);
        chk("t5_line", TBS_out, 1);
        chk("t5_busy", busy, 0);
        pend[3].push_back(8'h3C);
        wait_idle(2000);
        chk("t5_count", dec_log.size(), n0 + 1);
        if (dec_log.size() == n0 + 1) chk("t5_byte", dec_log[n0], 8'h3C);
        chk("t5_grant", grant_id, 3);

`ifdef TBS_TX_PARITY_EN
        pend[0].push_back(8'h07);
        capture(lows, dn);
        chk("t6_lows", lows, 12);
        chk("t6_parity", ln[181], 1);
        chk("t6_done", dn, 220);
        wait_idle(2000);
`endif

        rnd_mode = 1;
        repeat (40) begin
            pend[$urandom_range(N - 1)].push_back(8'($urandom));
            repeat ($urandom_range(300)) @(posedge clk_50M);
        end
        wait_idle(20000);
        rnd_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
